ack_arbiter_rr: RTL and testbench

Clocked, parametrised arbiter for the shared open-drain ack bus. It replaces the combinational fixed-priority ack arbitration with a registered grant, a choice of fixed or round-robin priority, and a hold-until-release handshake. It adds a timeout that masks a source that never drops its ack. It sits between the source modules (MEM=0, SHA=1, AES=2, CTRL=3 by default) and the ack bus wires.

---
 rtl/ack_arbiter_rr_if.sv | 27 ++
 rtl/ack_arbiter_rr.sv | 147 ++++++++++++++
 tb/tb_ack_arbiter_rr.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ack_arbiter_rr_if.sv
// Ack bus between the source modules and the arbiter.
// master = source side (drives ack_valid), slave = arbiter side.
interface ack_arbiter_rr_if #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2
);
    // A source raises ack_valid[i] and holds it until it sees ack_ready[i];
    // ack_ready is a one-cycle one-hot grant, after which the source may drop.
    logic [NUM_SRC-1:0] ack_valid;
    logic [NUM_SRC-1:0] ack_ready;
    logic               ack_valid_n;
    logic [ID_W-1:0]    winner_source_id;

    modport master (
        output ack_valid,
        input  ack_ready,
        input  ack_valid_n,
        input  winner_source_id
    );

    modport slave (
        input  ack_valid,
        output ack_ready,
        output ack_valid_n,
        output winner_source_id
    );
endinterface

// File: rtl/ack_arbiter_rr.sv
// Registered ack-bus arbiter: fixed or round-robin priority, grant held until the
// winner releases, optional hold timeout that masks a stuck source until it drops.
module ack_arbiter_rr #(
    parameter int NUM_SRC   = 4,
    parameter int ID_W      = 2,
    parameter int PRIO_MODE = 0,
    parameter int MAX_HOLD  = 16,
    parameter int CNT_W     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    ack_arbiter_rr_if.slave     bus,
    output logic                busy,
    output logic                timeout_err,
    output logic [1:0]          state_dbg
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        WAIT_DROP = 2'd2
    } state_e;

    localparam logic [ID_W-1:0]  ID_RST    = ID_W'(NUM_SRC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] ready_q, ready_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic               valid_n_q, valid_n_d;
    logic               busy_q, busy_d;
    logic               tmo_q, tmo_d;
    logic [ID_W-1:0]    win_q, win_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_SRC-1:0] eligible;
    logic [ID_W-1:0]    pick;
    logic               found;
    int                 idx;

    assign eligible = bus.ack_valid & ~mask_q;

    // Round-robin searches downward starting just below the last winner, so with
    // last=0 after reset the order matches fixed priority.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        if (PRIO_MODE == 0) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (eligible[i]) pick = ID_W'(i);
            end
        end else begin
            for (int k = 1; k <= NUM_SRC; k++) begin
                idx = (int'(last_q) + NUM_SRC - k) % NUM_SRC;
                if (!found && eligible[idx]) begin
                    pick  = ID_W'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ready_d   = '0;
        valid_n_d = 1'b1;
        win_d     = win_q;
        busy_d    = busy_q;
        tmo_d     = 1'b0;
        last_d    = last_q;
        cnt_d     = cnt_q;
        mask_d    = mask_q & bus.ack_valid;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d       = GRANT;
                    ready_d[pick] = 1'b1;
                    valid_n_d     = 1'b0;
                    win_d         = pick;
                    busy_d        = 1'b1;
                    last_d        = pick;
                end else begin
                    win_d  = ID_RST;
                    busy_d = 1'b0;
                end
            end
            GRANT: begin
                state_d = WAIT_DROP;
                cnt_d   = '0;
                busy_d  = 1'b1;
            end
            WAIT_DROP: begin
                if (!bus.ack_valid[win_q]) begin
                    state_d = IDLE;
                    win_d   = ID_RST;
                    busy_d  = 1'b0;
                end else if ((MAX_HOLD != 0) && (cnt_q == HOLD_LAST)) begin
                    // Stuck holder: release the bus and ignore it until it drops.
                    state_d       = IDLE;
                    win_d         = ID_RST;
                    busy_d        = 1'b0;
                    tmo_d         = 1'b1;
                    mask_d[win_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                win_d   = ID_RST;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ready_q   <= '0;
            valid_n_q <= 1'b1;
            win_q     <= ID_RST;
            busy_q    <= 1'b0;
            tmo_q     <= 1'b0;
            last_q    <= '0;
            mask_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            valid_n_q <= valid_n_d;
            win_q     <= win_d;
            busy_q    <= busy_d;
            tmo_q     <= tmo_d;
            last_q    <= last_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.ack_ready        = ready_q;
    assign bus.ack_valid_n      = valid_n_q;
    assign bus.winner_source_id = win_q;
    assign busy                 = busy_q;
    assign timeout_err          = tmo_q;
    assign state_dbg            = state_q;
endmodule

// File: tb/tb_ack_arbiter_rr.sv
// Bench for ack_arbiter_rr: four configurations (fixed, round-robin, timeout 4,
// timeout off) run from one clock; a monitor checks every grant against a queue.
module tb_ack_arbiter_rr;
    logic       clk;
    logic       rst_n;
    logic [3:0] v    [4];
    logic [3:0] rdy  [4];
    logic [3:0] pend1[4];
    logic [3:0] pend2[4];
    logic       busy [4];
    logic       tmo  [4];
    logic [1:0] st   [4];

    int checks = 0;
    int errors = 0;
    int tc[4];
    bit held_ok;

    logic [6:0] exp_q0[$];
    logic [6:0] exp_q1[$];
    logic [6:0] exp_q2[$];
    logic [6:0] exp_q3[$];

    ack_arbiter_rr_if #(.NUM_SRC(4), .ID_W(2)) if_a ();
    ack_arbiter_rr_if #(.NUM_SRC(4), .ID_W(2)) if_b ();
    ack_arbiter_rr_if #(.NUM_SRC(4), .ID_W(2)) if_c ();
    ack_arbiter_rr_if #(.NUM_SRC(4), .ID_W(2)) if_d ();

    assign if_a.ack_valid = v[0];
    assign if_b.ack_valid = v[1];
    assign if_c.ack_valid = v[2];
    assign if_d.ack_valid = v[3];
    assign rdy[0] = if_a.ack_ready;
    assign rdy[1] = if_b.ack_ready;
    assign rdy[2] = if_c.ack_ready;
    assign rdy[3] = if_d.ack_ready;

    ack_arbiter_rr #(.PRIO_MODE(0), .MAX_HOLD(16)) u_fix (
        .clk(clk), .rst_n(rst_n), .bus(if_a),
        .busy(busy[0]), .timeout_err(tmo[0]), .state_dbg(st[0]));
    ack_arbiter_rr #(.PRIO_MODE(1), .MAX_HOLD(16)) u_rr (
        .clk(clk), .rst_n(rst_n), .bus(if_b),
        .busy(busy[1]), .timeout_err(tmo[1]), .state_dbg(st[1]));
    ack_arbiter_rr #(.PRIO_MODE(0), .MAX_HOLD(4)) u_tmo (
        .clk(clk), .rst_n(rst_n), .bus(if_c),
        .busy(busy[2]), .timeout_err(tmo[2]), .state_dbg(st[2]));
    ack_arbiter_rr #(.PRIO_MODE(0), .MAX_HOLD(0)) u_hold (
        .clk(clk), .rst_n(rst_n), .bus(if_d),
        .busy(busy[3]), .timeout_err(tmo[3]), .state_dbg(st[3]));

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int k, input logic [1:0] id);
        logic [3:0] oh;
        logic [6:0] e;
        oh = 4'b0001 << id;
        e  = {1'b0, oh, id};
        case (k)
            0: exp_q0.push_back(e);
            1: exp_q1.push_back(e);
            2: exp_q2.push_back(e);
            default: exp_q3.push_back(e);
        endcase
    endtask

    task automatic pop_cmp(input int k, input logic [6:0] act);
        logic [6:0] e;
        bit got;
        e   = '0;
        got = 1'b0;
        case (k)
            0: if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); got = 1'b1; end
            1: if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); got = 1'b1; end
            2: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); got = 1'b1; end
            default: if (exp_q3.size() > 0) begin e = exp_q3.pop_front(); got = 1'b1; end
        endcase
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL grant%0d: unexpected grant {vn,ready,id}=%b, required none (t=%0t)", k, act, $time);
        end else begin
            check($sformatf("grant%0d {vn,ready,id}", k), 32'(act), 32'(e));
        end
    endtask

    // monitor: every presented grant is compared with the next expected one
    always @(negedge clk) begin
        if (|rdy[0]) pop_cmp(0, {if_a.ack_valid_n, rdy[0], if_a.winner_source_id});
        if (|rdy[1]) pop_cmp(1, {if_b.ack_valid_n, rdy[1], if_b.winner_source_id});
        if (|rdy[2]) pop_cmp(2, {if_c.ack_valid_n, rdy[2], if_c.winner_source_id});
        if (|rdy[3]) pop_cmp(3, {if_d.ack_valid_n, rdy[3], if_d.winner_source_id});
        for (int k = 0; k < 4; k++) if (tmo[k]) tc[k]++;
    end

    // ---------------- drivers ----------------
    // Source model: drops its valid on seeing ready, keeps it low through the
    // WAIT_DROP edge and, when rereq is set, raises it again one cycle later.
    task automatic step(input int k, input int n, input logic [3:0] drop_m, input bit rereq);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (rereq) v[k] = v[k] | pend2[k];
            pend2[k] = pend1[k];
            pend1[k] = rdy[k] & drop_m;
            v[k]     = v[k] & ~pend1[k];
        end
    endtask

    task automatic idle_src(input int k);
        v[k]     = '0;
        pend1[k] = '0;
        pend2[k] = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idle_src(k);
            tc[k] = 0;
        end
        repeat (3) @(negedge clk);
        check("rst ready", 32'(rdy[0]), 32'h0);
        check("rst valid_n", 32'(if_a.ack_valid_n), 32'h1);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle id", 32'(if_a.winner_source_id), 32'h3);
        check("idle busy", 32'(busy[0]), 32'h0);
        check("idle tmo", 32'(tmo[0]), 32'h0);

        // reset in the middle of a grant
        v[0] = 4'b1000;
        push(0, 2'd3);
        @(negedge clk);
        check("pre-reset busy", 32'(busy[0]), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("mid rst ready", 32'(rdy[0]), 32'h0);
        check("mid rst valid_n", 32'(if_a.ack_valid_n), 32'h1);
        check("mid rst id", 32'(if_a.winner_source_id), 32'h3);
        check("mid rst busy", 32'(busy[0]), 32'h0);
        @(negedge clk);
        push(0, 2'd3);
        rst_n = 1'b1;
        @(negedge clk);
        check("regrant ready", 32'(rdy[0]), 32'h8);
        v[0] = 4'b0000;
        repeat (3) @(negedge clk);
        check("after regrant busy", 32'(busy[0]), 32'h0);

        // single source, dropping during the grant cycle
        v[0] = 4'b0001;
        push(0, 2'd0);
        @(negedge clk);
        check("single grant state", 32'(st[0]), 32'h1);
        v[0] = 4'b0000;
        @(negedge clk);
        check("single wd valid_n", 32'(if_a.ack_valid_n), 32'h1);
        check("single wd ready", 32'(rdy[0]), 32'h0);
        check("single wd busy", 32'(busy[0]), 32'h1);
        check("single wd id", 32'(if_a.winner_source_id), 32'h0);
        @(negedge clk);
        check("single exit busy", 32'(busy[0]), 32'h0);
        check("single exit id", 32'(if_a.winner_source_id), 32'h3);

        // fixed priority: 2 then late-arriving 3 then 1
        v[0] = 4'b0110;
        push(0, 2'd2);
        push(0, 2'd3);
        push(0, 2'd1);
        step(0, 2, 4'b1111, 1'b0);
        v[0][3] = 1'b1;
        step(0, 10, 4'b1111, 1'b0);
        check("fixed drained busy", 32'(busy[0]), 32'h0);
        idle_src(0);

        // continuous re-request: fixed keeps granting 3, round-robin rotates
        v[0] = 4'b1111;
        v[1] = 4'b1111;
        for (int i = 0; i < 3; i++) push(0, 2'd3);
        push(1, 2'd3); push(1, 2'd2); push(1, 2'd1);
        push(1, 2'd0); push(1, 2'd3); push(1, 2'd2);
        fork
            begin
                step(0, 7, 4'b1111, 1'b1);
                idle_src(0);
            end
            begin
                step(1, 16, 4'b1111, 1'b1);
                idle_src(1);
            end
        join
        repeat (3) @(negedge clk);

        // timeout: source 1 never drops, source 0 drops after its grant
        v[2] = 4'b0011;
        push(2, 2'd1);
        push(2, 2'd0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 4) begin
                check($sformatf("tmo wd%0d busy", c), 32'(busy[2]), 32'h1);
                check($sformatf("tmo wd%0d err", c), 32'(tmo[2]), 32'h0);
            end
            if (c == 5) begin
                check("tmo pulse", 32'(tmo[2]), 32'h1);
                check("tmo idle busy", 32'(busy[2]), 32'h0);
            end
            if (c == 6) begin
                check("tmo pulse end", 32'(tmo[2]), 32'h0);
                check("tmo next grant busy", 32'(busy[2]), 32'h1);
            end
            if (rdy[2][0]) v[2][0] = 1'b0;
        end
        repeat (5) @(negedge clk);
        check("masked src idle", 32'(busy[2]), 32'h0);
        v[2] = 4'b0000;
        @(negedge clk);
        v[2] = 4'b0010;
        push(2, 2'd1);
        step(2, 4, 4'b1111, 1'b0);
        idle_src(2);

        // no timeout: hold for 300 cycles, then release
        v[3] = 4'b0010;
        push(3, 2'd1);
        @(negedge clk);
        held_ok = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!busy[3] || st[3] != 2'd2) held_ok = 1'b0;
        end
        check("hold 300 in wait_drop", 32'(held_ok), 32'h1);
        v[3] = 4'b0000;
        @(negedge clk);
        check("hold exit busy", 32'(busy[3]), 32'h0);
        check("hold exit state", 32'(st[3]), 32'h0);
        repeat (2) @(negedge clk);

        check("tmo count fixed16", 32'(tc[0]), 32'h0);
        check("tmo count rr16", 32'(tc[1]), 32'h0);
        check("tmo count max4", 32'(tc[2]), 32'h1);
        check("tmo count off", 32'(tc[3]), 32'h0);
        check("exp_q0 left", 32'(exp_q0.size()), 32'h0);
        check("exp_q1 left", 32'(exp_q1.size()), 32'h0);
        check("exp_q2 left", 32'(exp_q2.size()), 32'h0);
        check("exp_q3 left", 32'(exp_q3.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
